// File: rtl/dmac_pkg.sv
// ============================================================================
//  Module      : dmac_pkg
//  Description : Shared AHB-Lite encodings and the subordinate-memory state
//                type used by the DMA channel controller bench targets.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmac_pkg;

    // HTrans encodings
    localparam logic [1:0] c_htrans_idle    = 2'b00;
    localparam logic [1:0] c_htrans_busy    = 2'b01;
    localparam logic [1:0] c_htrans_non_seq = 2'b10;
    localparam logic [1:0] c_htrans_seq     = 2'b11;

    // HResp encodings
    localparam logic [1:0] c_hresp_okay  = 2'b00;
    localparam logic [1:0] c_hresp_error = 2'b01;

    // The only legal transfer size (32-bit word)
    localparam logic [2:0] c_hsize_word = 3'b010;

    // Subordinate memory data-phase state
    typedef enum logic [2:0] {
        IDLE_ST = 3'd0,
        WAIT_ST = 3'd1,
        DATA_ST = 3'd2,
        ERR1_ST = 3'd3,
        ERR2_ST = 3'd4
    } slv_state_e;

endpackage : dmac_pkg

`default_nettype wire

// File: rtl/ahb_slv_mem_array.sv
// ============================================================================
//  Module      : ahb_slv_mem_array
//  Description : Single-port DEPTH x DATA_W storage, synchronous write and
//                asynchronous read by word index. Isolated so it can later be
//                replaced by an SRAM macro wrapper. Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_slv_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Store write data at the completing edge of a write data phase
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : ahb_slv_mem_array

`default_nettype wire

// File: rtl/ahb_slave_mem.sv
// ============================================================================
//  Module      : ahb_slave_mem
//  Description : AHB-Lite subordinate memory with WAIT_CYCLES wait states per
//                NON_SEQ/SEQ data phase and a word-addressed internal array.
//                Optional macro AHB_SLV_ERR_EN: out-of-range, misaligned or
//                non-word transfers get a two-cycle ERROR response and write
//                data is discarded. Without it addresses wrap modulo DEPTH
//                and every transfer is treated as a word access.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_slave_mem
    import dmac_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSel,
    input  logic [ADDR_W-1:0] HAddr,
    input  logic [1:0]        HTrans,
    input  logic              HWrite,
    input  logic [2:0]        HSize,
    input  logic [DATA_W-1:0] HWData,
    input  logic              HReady,
    output logic              HReadyOut,
    output logic [1:0]        HResp,
    output logic [DATA_W-1:0] HRData
);

    localparam int         AW          = $clog2(DEPTH);
    localparam logic [3:0] c_wait_load = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    slv_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              write_q;
    logic              err_q, err_d;
    logic              hready_q;
    logic [1:0]        hresp_q;
    logic              accept;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_bits;

    // NON_SEQ and SEQ both have HTrans[1] set; IDLE/BUSY are never accepted
    assign accept = HSel && HReady && HTrans[1];
    assign addr_d = HAddr[AW+1:2];

`ifdef AHB_SLV_ERR_EN
    assign err_d = ((HAddr >> (AW + 2)) != '0)
                || (HSize != c_hsize_word)
                || (HAddr[1:0] != 2'b00);
`else
    assign err_d = 1'b0;
`endif

    // Bits only consulted by the error check, or not at all
    assign unused_bits = ^{HTrans[0], HAddr, HSize};

    // Next-state and wait-counter decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE_ST, DATA_ST, ERR2_ST: begin
                if (accept) begin
                    cnt_d = c_wait_load;
                    if (err_d) begin
                        state_d = ERR1_ST;
                    end else if (WAIT_CYCLES != 0) begin
                        state_d = WAIT_ST;
                    end else begin
                        state_d = DATA_ST;
                    end
                end else begin
                    state_d = IDLE_ST;
                end
            end
            WAIT_ST: begin
                if (cnt_q == 4'd0) begin
                    state_d = DATA_ST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef AHB_SLV_ERR_EN
            ERR1_ST: state_d = ERR2_ST;
`endif
            default: state_d = IDLE_ST;
        endcase
    end

    // State, address-phase capture and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE_ST;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= c_hresp_okay;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            if (accept && (state_q != WAIT_ST) && (state_q != ERR1_ST)) begin
                addr_q  <= addr_d;
                write_q <= HWrite;
                err_q   <= err_d;
            end
            hready_q <= (state_d != WAIT_ST) && (state_d != ERR1_ST);
            hresp_q  <= ((state_d == ERR1_ST) || (state_d == ERR2_ST)) ? c_hresp_error
                                                                        : c_hresp_okay;
        end
    end

    // Writes land only in the completing cycle of an error-free data phase
    assign mem_we = (state_q == DATA_ST) && write_q && !err_q;

    ahb_slv_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (addr_q),
        .wdata_i (HWData),
        .rdata_o (mem_rdata)
    );

    assign HReadyOut = hready_q;
    assign HResp     = hresp_q;
    assign HRData    = ((state_q == DATA_ST) && !write_q) ? mem_rdata : '0;

endmodule : ahb_slave_mem

`default_nettype wire
